// File: rtl/cond_pkg.sv
// Shared defaults for the conditional lookup pipeline.
//   SEL_W_DEF    : selector width (table holds 2**SEL_W entries)
//   OUT_W_DEF    : width of each mapped output code
//   DEF_VAL_DEF  : code returned for unprogrammed entries
//   HOLD_SEL_DEF : selector value that updates the hold register
//   CNT_W_DEF    : width of the saturating hit/miss counters
package cond_pkg;

    localparam int unsigned SEL_W_DEF    = 2;
    localparam int unsigned OUT_W_DEF    = 2;
    localparam int unsigned DEF_VAL_DEF  = 0;
    localparam int unsigned HOLD_SEL_DEF = 2;
    localparam int unsigned CNT_W_DEF    = 8;

endpackage : cond_pkg

// File: rtl/cond_lut_table.sv
// Lookup table storage: 2**SEL_W codes plus one valid bit per entry.
//   clk, rst : clock, async active-high reset (clears valid bits only)
//   we       : write strobe; stores wdata at waddr and marks it valid
//   waddr    : entry to write
//   wdata    : code to store
//   clr      : synchronous invalidate of all entries, wins over we
//   raddr    : combinational read address
//   rdata    : stored code at raddr (pre-write contents)
//   rvalid   : valid bit at raddr (pre-write contents)
module cond_lut_table
    import cond_pkg::*;
#(
    parameter int unsigned SEL_W = SEL_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [SEL_W-1:0] waddr,
    input  logic [OUT_W-1:0] wdata,
    input  logic             clr,
    input  logic [SEL_W-1:0] raddr,
    output logic [OUT_W-1:0] rdata,
    output logic             rvalid
);

    localparam int unsigned DEPTH = 2 ** SEL_W;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;

    // Code storage is never reset: an entry is unreachable until it is written.
    // A clear blocks a simultaneous write so the old code stays in place.
    always_ff @(posedge clk) begin
        if (we && !clr) begin
            mem[waddr] <= wdata;
        end
    end

    // Valid bits: clear has priority over write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else if (we) begin
            valid[waddr] <= 1'b1;
        end
    end

    // Combinational read port sees state before this cycle's write.
    assign rdata  = mem[raddr];
    assign rvalid = valid[raddr];

endmodule : cond_lut_table

// File: rtl/cond_lut_pipe.sv
// Single-stage lookup pipeline with valid/ready handshake, hold register
// and saturating hit/miss statistics.
//   clk, rst            : clock, async active-high reset
//   cfg_we/addr/data    : table write port
//   cfg_clr             : invalidate all table entries
//   in_valid/in_ready   : lookup request handshake (in_ready is combinational)
//   in_sel              : lookup selector
//   out_valid/out_ready : result handshake
//   out_data, out_hit   : mapped code and entry-valid flag of the lookup
//   hold_data           : last code mapped for HOLD_SEL
//   hit_cnt, miss_cnt   : saturating lookup statistics
module cond_lut_pipe
    import cond_pkg::*;
#(
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned OUT_W    = OUT_W_DEF,
    parameter int unsigned DEF_VAL  = DEF_VAL_DEF,
    parameter int unsigned HOLD_SEL = HOLD_SEL_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             cfg_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_hit,
    output logic [OUT_W-1:0] hold_data,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [OUT_W-1:0] DEF_CODE = OUT_W'(DEF_VAL);
    localparam logic [SEL_W-1:0] HOLD_IDX = SEL_W'(HOLD_SEL);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [OUT_W-1:0] tbl_data;
    logic             tbl_valid;
    logic             accept;
    logic [OUT_W-1:0] lookup_code;

    cond_lut_table #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .we     (cfg_we),
        .waddr  (cfg_addr),
        .wdata  (cfg_data),
        .clr    (cfg_clr),
        .raddr  (in_sel),
        .rdata  (tbl_data),
        .rvalid (tbl_valid)
    );

    // Stage is free when empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Unprogrammed entries map to the default code.
    always_comb begin
        lookup_code = DEF_CODE;
        if (tbl_valid) begin
            lookup_code = tbl_data;
        end
    end

    // Result register: load on accept, drop when drained, hold under back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= DEF_CODE;
            out_hit   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lookup_code;
            out_hit   <= tbl_valid;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Hold register tracks the latest accepted lookup of HOLD_SEL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= DEF_CODE;
        end else if (accept && (in_sel == HOLD_IDX)) begin
            hold_data <= lookup_code;
        end
    end

    // Saturating statistics, one count per accepted lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (tbl_valid) begin
                if (hit_cnt != CNT_MAX) begin
                    hit_cnt <= hit_cnt + CNT_W'(1);
                end
            end else if (miss_cnt != CNT_MAX) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule : cond_lut_pipe

// File: doc/cond_lut_pipe.md
COND_LUT_PIPE -- requirements
Module: cond_lut_pipe

Interface
REQ-001 SHALL have parameter SEL_W, default 2, selector width; the table holds 2**SEL_W entries.
REQ-002 SHALL have parameter OUT_W, default 2, width of each mapped output code.
REQ-003 SHALL have parameter DEF_VAL, default 0, code returned for unprogrammed entries.
REQ-004 SHALL have parameter HOLD_SEL, default 2, selector value that updates the hold register.
REQ-005 SHALL have parameter CNT_W, default 8, width of the hit and miss counters.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 cfg_we  input  1  table write strobe.
REQ-009 cfg_addr  input  SEL_W  table entry to write.
REQ-010 cfg_data  input  OUT_W  code to store.
REQ-011 cfg_clr  input  1  synchronous invalidate of all entries.
REQ-012 in_valid  input  1  lookup request valid.
REQ-013 in_ready  output  1  block can accept a lookup.
REQ-014 in_sel  input  SEL_W  lookup selector.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_data  output  OUT_W  mapped code.
REQ-018 out_hit  output  1  1 if the entry was programmed at lookup time.
REQ-019 hold_data  output  OUT_W  last code mapped for HOLD_SEL.
REQ-020 hit_cnt, miss_cnt  output  CNT_W each  saturating lookup statistics.

Function
REQ-021 Table: 2**SEL_W entries, each OUT_W code plus one valid bit.
REQ-022 cfg_we=1 writes cfg_data to entry cfg_addr and sets its valid bit at the next edge.
REQ-023 cfg_clr=1 clears all valid bits and leaves stored codes unchanged; it has priority over a cfg_we in the same cycle.
REQ-024 Lookup accept occurs when in_valid && in_ready.
REQ-025 in_ready = !out_valid || out_ready; this is combinational and gives full throughput with back-pressure.
REQ-026 Latency: result appears on out_valid/out_data/out_hit one cycle after accept.
REQ-027 On accept, out_data = stored code if the entry is valid, else DEF_VAL; out_hit = the entry valid bit.
REQ-028 A lookup and a write to the same entry in the same cycle SHALL return the pre-write contents (read-before-write).
REQ-029 While out_valid && !out_ready, out_data/out_hit/out_valid SHALL hold stable.
REQ-030 An out_valid that is accepted with no new request SHALL drop out_valid to 0 at the next edge.
REQ-031 hold_data updates to the accepted result's out_data only when the accepted in_sel == HOLD_SEL; otherwise it retains its value. It is a flop with enable; no latch is inferred anywhere.
REQ-032 Each accept increments hit_cnt if out_hit, else miss_cnt; counters saturate at all-ones.
REQ-033 All combinational decode SHALL assign every output on every path (full default/else coverage).

Reset
REQ-034 rst asserted asynchronously clears: all valid bits, out_valid=0, out_data=DEF_VAL, out_hit=0, hold_data=DEF_VAL, hit_cnt=0, miss_cnt=0.
REQ-035 Stored table codes need not be reset; they are unreachable while invalid.
REQ-036 A result pending at rst assertion is discarded; in_ready=1 in the first cycle after deassertion.

Structure
REQ-037 Shared package cond_pkg SHALL hold the default values of SEL_W, OUT_W, DEF_VAL, HOLD_SEL and CNT_W.
REQ-038 The table storage and the valid bits SHALL be one sub-module, cond_lut_table (write port, clear, one combinational read port).
REQ-039 The handshake register, hold register and counters SHALL reside in cond_lut_pipe.

Verification
REQ-040 After reset, lookup sel=1 with no writes -> out_data=0, out_hit=0, miss_cnt=1, one cycle later.
REQ-041 Write entries {0:1,1:2,2:3,3:0}, then look up 0,1,2,3 back-to-back with out_ready=1 -> outputs 1,2,3,0 on consecutive cycles, hit_cnt=4, hold_data=3 after sel=2.
REQ-042 Hold out_ready=0 for 3 cycles with a result pending -> out_data stable, in_ready=0, counters do not change beyond the one pending accept.
REQ-043 Write entry 1=3 and look up sel=1 in the same cycle, where the old value was 2 -> out_data=2; the next lookup of sel=1 returns 3.
REQ-044 With CNT_W=2, perform 5 misses -> miss_cnt saturates at 3; then assert cfg_clr together with cfg_we and look up -> out_hit=0.
REQ-045 Assert rst mid-stream with out_valid=1 -> all outputs take their REQ-034 values immediately, without waiting for a clock edge.
